// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver FSM encoding, baud divisor
// calculation, 3-sample majority vote and the line idle level.
// Honours UART_RX_PARITY_EN (adds the PARITY state to the FSM encoding).
package uart_pkg;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } uart_rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baudrate,
                                             input int unsigned oversample);
        int unsigned den;
        den = baudrate * oversample;
        return (clk_freq + den / 2) / den;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-clk tick every DIV clocks, held at zero while
// restart is high so the first tick lands DIV clocks after restart drops.
module uart_baud_tick #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TOP = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_baud_tick: DIV must be at least 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;

    // Divider counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Next count and tick decode.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || cnt_q == TOP) cnt_d = '0;
        tick = !restart && (cnt_q == TOP);
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority voting and a
// valid/ready output register. Optional parity checking is compiled in
// when UART_RX_PARITY_EN is defined; otherwise parity_err_o is tied low.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 200_000_000,
    parameter int unsigned BAUDRATE   = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned DIV = uart_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);

    localparam logic [SW-1:0] SMP_A     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SMP_B     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SMP_C     = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] LAST_SMP  = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    uart_rx_state_t state_q, state_d;

    logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic                 smp_a_q, smp_a_d, smp_b_q, smp_b_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 parity_err_q, parity_err_d;
`else
    logic                 unused_parity_odd;
`endif

    logic tick, restart, start_edge, hit_a, hit_b, hit_c, bit_end, vote, frame_done;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick   (tick)
    );

    // Sample-point decode and majority vote shared by the FSM and datapath.
    always_comb begin
        start_edge = rx_prev_q & ~rx_s2_q;
        hit_a      = tick && (scnt_q == SMP_A);
        hit_b      = tick && (scnt_q == SMP_B);
        hit_c      = tick && (scnt_q == SMP_C);
        bit_end    = tick && (scnt_q == LAST_SMP);
        vote       = maj3(smp_a_q, smp_b_q, rx_s2_q);
        frame_done = (state_q == RX_STOP) && hit_c && (bcnt_q == LAST_STOP);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RX_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; the last stop bit ends at its third sample, not at bit end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (start_edge) state_d = RX_START;
            RX_START: begin
                if (hit_c && vote) state_d = RX_IDLE;
                else if (bit_end)  state_d = RX_DATA;
            end
            RX_DATA: begin
                if (bit_end && bcnt_q == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
                    state_d = RX_PARITY;
`else
                    state_d = RX_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: if (bit_end) state_d = RX_STOP;
`endif
            RX_STOP:  if (frame_done) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    // Datapath registers: synchroniser, counters, shifter and output hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q     <= UART_IDLE_LEVEL;
            rx_s2_q     <= UART_IDLE_LEVEL;
            rx_prev_q   <= UART_IDLE_LEVEL;
            scnt_q      <= '0;
            bcnt_q      <= '0;
            smp_a_q     <= UART_IDLE_LEVEL;
            smp_b_q     <= UART_IDLE_LEVEL;
            shreg_q     <= '0;
            ferr_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            rx_prev_q   <= rx_prev_d;
            scnt_q      <= scnt_d;
            bcnt_q      <= bcnt_d;
            smp_a_q     <= smp_a_d;
            smp_b_q     <= smp_b_d;
            shreg_q     <= shreg_d;
            ferr_q      <= ferr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Datapath next-state logic.
    always_comb begin
        rx_s1_d     = rx;
        rx_s2_d     = rx_s1_q;
        rx_prev_d   = rx_s2_q;
        scnt_d      = scnt_q;
        bcnt_d      = bcnt_q;
        smp_a_d     = smp_a_q;
        smp_b_d     = smp_b_q;
        shreg_d     = shreg_q;
        ferr_d      = ferr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = frame_done && valid_q && !ready_i;
`ifdef UART_RX_PARITY_EN
        perr_d       = perr_q;
        parity_err_d = parity_err_q;
`endif

        if (state_q == RX_IDLE) scnt_d = '0;
        else if (tick)          scnt_d = bit_end ? '0 : scnt_q + 1'b1;

        // Bit index restarts on every state change, counts bit ends within a state.
        if (state_d != state_q) bcnt_d = '0;
        else if (bit_end)       bcnt_d = bcnt_q + 1'b1;

        if (hit_a) smp_a_d = rx_s2_q;
        if (hit_b) smp_b_d = rx_s2_q;

        if (state_q == RX_DATA && hit_c) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};

        if (state_q == RX_IDLE)                       ferr_d = 1'b0;
        else if (state_q == RX_STOP && hit_c && !vote) ferr_d = 1'b1;

`ifdef UART_RX_PARITY_EN
        if (state_q == RX_IDLE)
            perr_d = 1'b0;
        else if (state_q == RX_PARITY && hit_c)
            perr_d = vote ^ (^shreg_q) ^ 1'(PARITY_ODD);
`endif

        // Completed frame loads unless the held frame is still unaccepted.
        if (frame_done && (!valid_q || ready_i)) begin
            data_d      = shreg_q;
            frame_err_d = ferr_q | ~vote;
            valid_d     = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = perr_q;
`endif
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Outputs.
    always_comb begin
        restart     = (state_q == RX_IDLE);
        busy_o      = (state_q != RX_IDLE);
        data_o      = data_q;
        valid_o     = valid_q;
        frame_err_o = frame_err_q;
        overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
        parity_err_o = parity_err_q;
`else
        parity_err_o      = 1'b0;
        unused_parity_odd = 1'(PARITY_ODD);
`endif
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os at DIV=10 (160 clk per bit).
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os;

    localparam int unsigned CLK_FREQ   = 1_536_000;
    localparam int unsigned BAUDRATE   = 9600;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned PARITY_ODD = 0;
    localparam int          BIT_CLKS   = CLK_FREQ / BAUDRATE;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, parity_err_o, overrun_o, busy_o;

    int errors = 0;
    int checks = 0;

    logic [9:0] obs_q[$];
    int         valid_cycles = 0;
    int         overrun_cycles = 0;

    always #5 clk = ~clk;

    uart_rx_os #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUDRATE  (BAUDRATE),
        .OVERSAMPLE(OVERSAMPLE),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    // Records every accepted output as {parity_err, frame_err, data}.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o && ready_i) obs_q.push_back({parity_err_o, frame_err_o, data_o});
            if (valid_o)   valid_cycles++;
            if (overrun_o) overrun_cycles++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: what a receiver must report for a frame as transmitted.
    function automatic logic [9:0] model(input logic [7:0] d, input logic stop_v, input logic par_v);
        logic perr;
        perr = PAR_EN && (par_v != ((^d) ^ (PARITY_ODD != 0)));
        return {perr, ~stop_v, d};
    endfunction

    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        idle(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par_v);
        for (int i = 0; i < int'(STOP_BITS); i++) drive_bit(stop_v);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(4);
        checks++; if (data_o !== 8'h00)    begin errors++; $display("FAIL reset_data: got %0h expected 0", data_o); end
        checks++; if (valid_o !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %0b expected 0", frame_err_o); end
        checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL reset_perr: got %0b expected 0", parity_err_o); end
        checks++; if (overrun_o !== 1'b0)  begin errors++; $display("FAIL reset_overrun: got %0b expected 0", overrun_o); end
        checks++; if (busy_o !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
        rst_n = 1'b1;
        idle(20);
    endtask

    task automatic test_basic;
        int n0, v0;
        logic [7:0] d;
        logic [9:0] got;
        d = 8'hA5;
        n0 = obs_q.size();
        v0 = valid_cycles;
        ready_i = 1'b1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(good_par(d));
        rx = 1'b1;
        idle(BIT_CLKS * 3 / 4);
        checks++;
        if (obs_q.size() != n0 + 1) begin
            errors++; $display("FAIL basic_early_valid: got %0d outputs expected 1 before stop bit end", obs_q.size() - n0);
        end
        idle(BIT_CLKS);
        got = (obs_q.size() > n0) ? obs_q[n0] : 'x;
        checks++; if (got !== model(d, 1'b1, good_par(d))) begin errors++; $display("FAIL basic_frame: got %0h expected %0h", got, model(d, 1'b1, good_par(d))); end
        checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL basic_valid_pulse: got %0d cycles expected 1", valid_cycles - v0); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %0b expected 0", valid_o); end
    endtask

    task automatic test_false_start;
        int n0, v0;
        n0 = obs_q.size();
        v0 = valid_cycles;
        rx = 1'b0;
        idle(20);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %0b expected 1", busy_o); end
        idle(20);
        rx = 1'b1;
        idle(BIT_CLKS - 40);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %0b expected 0", busy_o); end
        idle(BIT_CLKS * 2);
        checks++; if (obs_q.size() != n0 || valid_cycles != v0) begin
            errors++; $display("FAIL glitch_no_output: got %0d outputs expected 0", obs_q.size() - n0);
        end
    endtask

    task automatic test_frame_err;
        int n0;
        logic [9:0] got;
        n0 = obs_q.size();
        send_frame(8'h3C, 1'b0, good_par(8'h3C));
        idle(BIT_CLKS);
        got = (obs_q.size() > n0) ? obs_q[n0] : 'x;
        checks++; if (got !== model(8'h3C, 1'b0, good_par(8'h3C))) begin errors++; $display("FAIL frame_err: got %0h expected %0h", got, model(8'h3C, 1'b0, good_par(8'h3C))); end
    endtask

    task automatic test_break;
        int n0;
        logic [9:0] got;
        n0 = obs_q.size();
        rx = 1'b0;
        idle(BIT_CLKS * 14);
        got = (obs_q.size() > n0) ? obs_q[n0] : 'x;
        checks++; if (obs_q.size() != n0 + 1) begin errors++; $display("FAIL break_count: got %0d outputs expected 1", obs_q.size() - n0); end
        checks++; if (got !== model(8'h00, 1'b0, 1'b0)) begin errors++; $display("FAIL break_frame: got %0h expected %0h", got, model(8'h00, 1'b0, 1'b0)); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL break_idle_wait: got busy %0b expected 0", busy_o); end
        rx = 1'b1;
        idle(BIT_CLKS);
        send_frame(8'h81, 1'b1, good_par(8'h81));
        idle(BIT_CLKS);
        got = (obs_q.size() > n0 + 1) ? obs_q[n0+1] : 'x;
        checks++; if (got !== model(8'h81, 1'b1, good_par(8'h81))) begin errors++; $display("FAIL break_recover: got %0h expected %0h", got, model(8'h81, 1'b1, good_par(8'h81))); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int n0;
        logic [9:0] got;
        n0 = obs_q.size();
        send_frame(8'h07, 1'b1, 1'b0);
        idle(BIT_CLKS);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(BIT_CLKS);
        got = (obs_q.size() > n0) ? obs_q[n0] : 'x;
        checks++; if (got !== {1'b1, 1'b0, 8'h07}) begin errors++; $display("FAIL parity_bad: got %0h expected %0h", got, {1'b1, 1'b0, 8'h07}); end
        got = (obs_q.size() > n0 + 1) ? obs_q[n0+1] : 'x;
        checks++; if (got !== {1'b0, 1'b0, 8'h07}) begin errors++; $display("FAIL parity_good: got %0h expected %0h", got, {1'b0, 1'b0, 8'h07}); end
    endtask
`endif

    task automatic test_overrun;
        int n0, o0;
        logic [9:0] got;
        n0 = obs_q.size();
        o0 = overrun_cycles;
        ready_i = 1'b0;
        send_frame(8'h11, 1'b1, good_par(8'h11));
        send_frame(8'h22, 1'b1, good_par(8'h22));
        idle(BIT_CLKS);
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL overrun_valid_held: got %0b expected 1", valid_o); end
        checks++; if (data_o !== 8'h11) begin errors++; $display("FAIL overrun_data_held: got %0h expected 11", data_o); end
        checks++; if (overrun_cycles - o0 != 1) begin errors++; $display("FAIL overrun_pulse: got %0d cycles expected 1", overrun_cycles - o0); end
        ready_i = 1'b1;
        idle(1);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL overrun_valid_drop: got %0b expected 0", valid_o); end
        got = (obs_q.size() > n0) ? obs_q[n0] : 'x;
        checks++; if (obs_q.size() != n0 + 1 || got !== model(8'h11, 1'b1, good_par(8'h11))) begin
            errors++; $display("FAIL overrun_accept: got %0h (%0d outputs) expected %0h", got, obs_q.size() - n0, model(8'h11, 1'b1, good_par(8'h11)));
        end
        idle(BIT_CLKS);
    endtask

    task automatic test_reset_mid;
        int n0;
        logic [7:0] d;
        logic [9:0] got;
        d = 8'h96;
        n0 = obs_q.size();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx = d[4];
        idle(BIT_CLKS / 2);
        rst_n = 1'b0;
        rx = 1'b1;
        idle(5);
        checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("FAIL midreset_state: got busy %0b valid %0b expected 0 0", busy_o, valid_o); end
        rst_n = 1'b1;
        idle(BIT_CLKS * 2);
        checks++; if (obs_q.size() != n0) begin errors++; $display("FAIL midreset_no_output: got %0d outputs expected 0", obs_q.size() - n0); end
        send_frame(8'h5A, 1'b1, good_par(8'h5A));
        idle(BIT_CLKS);
        got = (obs_q.size() > n0) ? obs_q[n0] : 'x;
        checks++; if (got !== model(8'h5A, 1'b1, good_par(8'h5A))) begin errors++; $display("FAIL midreset_next: got %0h expected %0h", got, model(8'h5A, 1'b1, good_par(8'h5A))); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp_q[$];
        logic [9:0] got;
        logic [7:0] d;
        logic       stop_v, par_v;
        int         n0, v0;
        n0 = obs_q.size();
        v0 = valid_cycles;
        ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d      = 8'($urandom);
            stop_v = ($urandom_range(0, 3) != 0);
            par_v  = good_par(d) ^ ($urandom_range(0, 3) == 0);
            exp_q.push_back(model(d, stop_v, par_v));
            send_frame(d, stop_v, par_v);
            if (!stop_v || $urandom_range(0, 2) == 0) drive_bit(1'b1);
        end
        idle(BIT_CLKS * 2);
        checks++; if (obs_q.size() - n0 != 10) begin errors++; $display("FAIL b2b_count: got %0d outputs expected 10", obs_q.size() - n0); end
        checks++; if (valid_cycles - v0 != 10) begin errors++; $display("FAIL b2b_valid_cycles: got %0d expected 10", valid_cycles - v0); end
        for (int k = 0; k < 10; k++) begin
            got = (obs_q.size() > n0 + k) ? obs_q[n0+k] : 'x;
            checks++;
            if (got !== exp_q[k]) begin
                errors++; $display("FAIL b2b_frame%0d: got %0h expected %0h", k, got, exp_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_break();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
